// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU-side requesters, the ram_arbiter and the single-port ram.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          busy;
  logic          read_ram;
  logic          write_ram;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_write_data;
  logic [DW-1:0] ram_out;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           busy, read_ram, write_ram, ram_addr, ram_write_data
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_out,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           busy, read_ram, write_ram, ram_addr, ram_write_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares a single-port ram (1-cycle registered read) between instruction fetch and data ports.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise data always beats fetch.
module ram_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;

  logic grant_any, grant_data, grant_store;

  logic          cmd_data, cmd_data_next;
  logic          cmd_we, cmd_we_next;
  logic          if_gnt_reg, if_gnt_next;
  logic          d_gnt_reg, d_gnt_next;
  logic          if_rvalid_reg, if_rvalid_next;
  logic          d_rvalid_reg, d_rvalid_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] d_rdata_reg, d_rdata_next;
  logic          busy_reg, busy_next;
  logic          read_ram_reg, read_ram_next;
  logic          write_ram_reg, write_ram_next;
  logic [AW-1:0] ram_addr_reg, ram_addr_next;
  logic [DW-1:0] ram_write_data_reg, ram_write_data_next;

`ifdef RAM_ARB_RR_EN
  // 1 = data port was granted last; resets to data so the first tie goes to fetch.
  logic last_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_data <= 1'b1;
    end else if (state == IDLE && grant_any) begin
      last_data <= grant_data;
    end
  end
`endif

  always_comb begin
    grant_any   = bus.if_req | bus.d_req;
`ifdef RAM_ARB_RR_EN
    grant_data  = bus.d_req & (~bus.if_req | ~last_data);
`else
    grant_data  = bus.d_req;
`endif
    grant_store = grant_data & bus.d_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_any ? ACCESS : IDLE;
      ACCESS:  state_next = cmd_we ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Computes the next value of every registered output; enables and pulses default low.
  always_comb begin
    cmd_data_next       = cmd_data;
    cmd_we_next         = cmd_we;
    if_gnt_next         = 1'b0;
    d_gnt_next          = 1'b0;
    if_rvalid_next      = 1'b0;
    d_rvalid_next       = 1'b0;
    if_rdata_next       = if_rdata_reg;
    d_rdata_next        = d_rdata_reg;
    read_ram_next       = 1'b0;
    write_ram_next      = 1'b0;
    ram_addr_next       = ram_addr_reg;
    ram_write_data_next = ram_write_data_reg;
    busy_next           = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (grant_any) begin
          cmd_data_next       = grant_data;
          cmd_we_next         = grant_store;
          if_gnt_next         = ~grant_data;
          d_gnt_next          = grant_data;
          read_ram_next       = ~grant_store;
          write_ram_next      = grant_store;
          ram_addr_next       = grant_data ? bus.d_addr : bus.if_addr;
          ram_write_data_next = grant_store ? bus.d_wdata : '0;
        end
      end
      RESP: begin
        if (cmd_data) begin
          d_rdata_next  = bus.ram_out;
          d_rvalid_next = 1'b1;
        end else begin
          if_rdata_next  = bus.ram_out;
          if_rvalid_next = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_data           <= 1'b0;
      cmd_we             <= 1'b0;
      if_gnt_reg         <= 1'b0;
      d_gnt_reg          <= 1'b0;
      if_rvalid_reg      <= 1'b0;
      d_rvalid_reg       <= 1'b0;
      if_rdata_reg       <= '0;
      d_rdata_reg        <= '0;
      busy_reg           <= 1'b0;
      read_ram_reg       <= 1'b0;
      write_ram_reg      <= 1'b0;
      ram_addr_reg       <= '0;
      ram_write_data_reg <= '0;
    end else begin
      cmd_data           <= cmd_data_next;
      cmd_we             <= cmd_we_next;
      if_gnt_reg         <= if_gnt_next;
      d_gnt_reg          <= d_gnt_next;
      if_rvalid_reg      <= if_rvalid_next;
      d_rvalid_reg       <= d_rvalid_next;
      if_rdata_reg       <= if_rdata_next;
      d_rdata_reg        <= d_rdata_next;
      busy_reg           <= busy_next;
      read_ram_reg       <= read_ram_next;
      write_ram_reg      <= write_ram_next;
      ram_addr_reg       <= ram_addr_next;
      ram_write_data_reg <= ram_write_data_next;
    end
  end

  assign bus.if_gnt         = if_gnt_reg;
  assign bus.d_gnt          = d_gnt_reg;
  assign bus.if_rvalid      = if_rvalid_reg;
  assign bus.d_rvalid       = d_rvalid_reg;
  assign bus.if_rdata       = if_rdata_reg;
  assign bus.d_rdata        = d_rdata_reg;
  assign bus.busy           = busy_reg;
  assign bus.read_ram       = read_ram_reg;
  assign bus.write_ram      = write_ram_reg;
  assign bus.ram_addr       = ram_addr_reg;
  assign bus.ram_write_data = ram_write_data_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle-read ram; expectations follow
// RAM_ARB_RR_EN when it is defined.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic reset;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ram with a backdoor write port for preloading contents.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ram_out_reg;
  logic          bk_we;
  logic [7:0]    bk_addr;
  logic [DW-1:0] bk_data;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (bus.write_ram) mem[bus.ram_addr[7:0]] <= bus.ram_write_data;
    if (bus.read_ram) ram_out_reg <= mem[bus.ram_addr[7:0]];
  end

  assign bus.ram_out = ram_out_reg;

  int checks;
  int errors;

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr, input logic dReq,
                               input logic dWe, input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [DW-1:0] data);
    bk_addr = addr;
    bk_data = data;
    bk_we   = 1'b1;
    stepCycle();
    bk_we   = 1'b0;
  endtask

  // Returns 0 for a fetch grant, 1 for a data grant, 2 if no grant within the budget.
  task automatic waitGrant(output int port);
    port = 2;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (bus.d_gnt) begin
        port = 1;
        break;
      end
      if (bus.if_gnt) begin
        port = 0;
        break;
      end
    end
  endtask

  int port;
  int expTie [0:5];
  logic [DW-1:0] expB2b [0:3];
  int gntCycle [0:3];
  int gntCount;
  int rvCount;

  initial begin
    checks = 0;
    errors = 0;
    bk_we = 1'b0;
    bk_addr = '0;
    bk_data = '0;
    reset = 1'b1;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
`ifdef RAM_ARB_RR_EN
    expTie = '{1 => 1, 2 => 0, 3 => 1, 4 => 0, 5 => 1, default: 0};
`else
    expTie = '{default: 1};
    expTie[1] = 0;
`endif
    expB2b = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    @(negedge clk);

    $display("[TB] preload ram and hold reset with both requests high");
    preload(8'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(4 * i), expB2b[i]);
    stepCycle();
    stepCycle();
    checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_read_ram", 32'(bus.read_ram), 32'd0);
    checkOutput("rst_write_ram", 32'(bus.write_ram), 32'd0);
    checkOutput("rst_ram_addr", bus.ram_addr, 32'd0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
    checkOutput("rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] single fetch from 0x10");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("f_if_gnt_c1", 32'(bus.if_gnt), 32'd1);
    checkOutput("f_read_ram_c1", 32'(bus.read_ram), 32'd1);
    checkOutput("f_ram_addr_c1", bus.ram_addr, 32'h10);
    checkOutput("f_wdata_c1", bus.ram_write_data, 32'h0);
    checkOutput("f_busy_c1", 32'(bus.busy), 32'd1);
    bus.if_req = 1'b0;
    stepCycle();
    checkOutput("f_read_ram_c2", 32'(bus.read_ram), 32'd0);
    checkOutput("f_if_rvalid_c2", 32'(bus.if_rvalid), 32'd0);
    stepCycle();
    checkOutput("f_if_rvalid_c3", 32'(bus.if_rvalid), 32'd1);
    checkOutput("f_if_rdata_c3", bus.if_rdata, 32'hDEAD_BEEF);
    checkOutput("f_busy_c3", 32'(bus.busy), 32'd0);
    stepCycle();
    checkOutput("f_if_rvalid_c4", 32'(bus.if_rvalid), 32'd0);
    checkOutput("f_if_rdata_hold", bus.if_rdata, 32'hDEAD_BEEF);

    $display("[TB] store 0x12345678 to 0x20 then load it back");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    stepCycle();
    checkOutput("s_d_gnt", 32'(bus.d_gnt), 32'd1);
    checkOutput("s_write_ram", 32'(bus.write_ram), 32'd1);
    checkOutput("s_read_ram", 32'(bus.read_ram), 32'd0);
    checkOutput("s_ram_addr", bus.ram_addr, 32'h20);
    checkOutput("s_wdata", bus.ram_write_data, 32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    stepCycle();
    checkOutput("s_write_ram_off", 32'(bus.write_ram), 32'd0);
    checkOutput("s_busy_idle", 32'(bus.busy), 32'd0);
    stepCycle();
    checkOutput("l_d_gnt", 32'(bus.d_gnt), 32'd1);
    checkOutput("l_read_ram", 32'(bus.read_ram), 32'd1);
    checkOutput("l_wdata_zero", bus.ram_write_data, 32'h0);
    bus.d_req = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("l_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    checkOutput("l_d_rdata", bus.d_rdata, 32'h1234_5678);
    checkOutput("l_if_rdata_kept", bus.if_rdata, 32'hDEAD_BEEF);
    checkOutput("l_if_rvalid", 32'(bus.if_rvalid), 32'd0);

    $display("[TB] reset pointer, then tie between fetch and data");
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    waitGrant(port);
    checkOutput("tie_first", 32'(port), 32'(expTie[0] == 0 ? 1 : 0) ^ 32'd0 ^ 32'(expTie[0]) ^ 32'(expTie[0] == 0 ? 1 : 0));
    if (port == 1) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    waitGrant(port);
    checkOutput("tie_second", 32'(port), 32'(expTie[1]));
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 2; k < 6; k++) begin
      waitGrant(port);
      checkOutput($sformatf("tie_cont_%0d", k - 2), 32'(port), 32'(expTie[k]));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) stepCycle();

    $display("[TB] reset while a fetch is in its response cycle");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("mr_if_gnt", 32'(bus.if_gnt), 32'd1);
    bus.if_req = 1'b0;
    stepCycle();
    checkOutput("mr_busy_resp", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("mr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    checkOutput("mr_read_ram", 32'(bus.read_ram), 32'd0);
    checkOutput("mr_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("mr_if_rvalid_after", 32'(bus.if_rvalid), 32'd0);
    checkOutput("mr_if_gnt_after", 32'(bus.if_gnt), 32'd0);

    $display("[TB] four back-to-back fetches");
    gntCount = 0;
    rvCount = 0;
    gntCycle = '{default: 0};
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      stepCycle();
      if (bus.if_gnt) begin
        if (gntCount < 4) gntCycle[gntCount] = c;
        gntCount++;
        if (gntCount < 4) bus.if_addr = 32'h40 + 32'(4 * gntCount);
        else bus.if_req = 1'b0;
      end
      if (bus.if_rvalid) begin
        if (rvCount < 4) checkOutput($sformatf("b2b_data_%0d", rvCount), bus.if_rdata, expB2b[rvCount]);
        rvCount++;
      end
    end
    checkOutput("b2b_gnt_count", 32'(gntCount), 32'd4);
    checkOutput("b2b_rvalid_count", 32'(rvCount), 32'd4);
    checkOutput("b2b_first_gnt", 32'(gntCycle[0]), 32'd1);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("b2b_gap_%0d", i), 32'(gntCycle[i] - gntCycle[i-1]), 32'd3);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
